// File: rtl/sum_display_driver_if.sv
// Load/result/display bundle between the adder stage, the BCD display driver
// and the board's 2-digit 7-segment display.
interface sum_display_driver_if;
   logic [4:0] Sum_in;
   logic       Valid_in;
   logic       Busy_out;
   logic [7:0] Bcd_out;
   logic [6:0] Seg_out;
   logic [1:0] Dig_out;

   modport master (
      output Sum_in, Valid_in,
      input  Busy_out, Bcd_out, Seg_out, Dig_out
   );

   modport slave (
      input  Sum_in, Valid_in,
      output Busy_out, Bcd_out, Seg_out, Dig_out
   );
endinterface

// File: rtl/sum_display_driver.sv
// Captures a 5-bit sum, converts it to two BCD digits with a sequential
// double-dabble engine and drives a multiplexed 2-digit 7-segment display.
module sum_display_driver #(
   parameter int CLK_HZ         = 50000000,
   parameter int REFRESH_HZ     = 1000,
   parameter bit ACTIVE_LOW_SEG = 1'b1
) (
   input  logic                 Clk_in,
   input  logic                 Rst_n_in,
   sum_display_driver_if.slave  bus
);

   localparam int DIV = CLK_HZ / (2 * REFRESH_HZ);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [6:0]    SEG_POL = ACTIVE_LOW_SEG ? 7'h00 : 7'h7F;
   localparam logic [1:0]    DIG_POL = ACTIVE_LOW_SEG ? 2'b00 : 2'b11;
   localparam logic [6:0]    SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state;
   logic [12:0] sh;
   logic [2:0]  step;
   logic [CW-1:0] cnt;
   logic        sel_tens;

   // One shift-add-3 step over the {tens, ones, bin} register.
   function automatic logic [12:0] dabble_step(input logic [12:0] r);
      logic [12:0] a;
      a = r;
      if (a[12:9] >= 4'd5) a[12:9] = a[12:9] + 4'd3;
      if (a[8:5]  >= 4'd5) a[8:5]  = a[8:5]  + 4'd3;
      return a << 1;
   endfunction

   // Active-low gfedcba patterns; out-of-range digits blank.
   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return SEG_BLANK;
      endcase
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge Clk_in or negedge Rst_n_in) begin
      if (!Rst_n_in) begin
         state        <= IDLE;
         sh           <= '0;
         step         <= '0;
         bus.Busy_out <= 1'b0;
         bus.Bcd_out  <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Valid_in) begin
                  sh           <= {8'h00, bus.Sum_in};
                  step         <= '0;
                  bus.Busy_out <= 1'b1;
                  state        <= SHIFT;
               end
            end
            SHIFT: begin
               sh   <= dabble_step(sh);
               step <= step + 3'd1;
               if (step == 3'd4) state <= DONE;
            end
            DONE: begin
               bus.Bcd_out  <= sh[12:5];
               bus.Busy_out <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Refresh runs free of the converter; outputs follow the select before it toggles.
   always_ff @(posedge Clk_in or negedge Rst_n_in) begin
      if (!Rst_n_in) begin
         cnt         <= '0;
         sel_tens    <= 1'b0;
         bus.Seg_out <= SEG_BLANK ^ SEG_POL;
         bus.Dig_out <= 2'b11 ^ DIG_POL;
      end else begin
         if (cnt == CNT_MAX) begin
            cnt      <= '0;
            sel_tens <= ~sel_tens;
         end else begin
            cnt <= cnt + 1'b1;
         end

         if (sel_tens) begin
            bus.Dig_out <= 2'b01 ^ DIG_POL;
            bus.Seg_out <= ((bus.Bcd_out[7:4] == 4'd0) ? SEG_BLANK
                                                       : seg_pattern(bus.Bcd_out[7:4])) ^ SEG_POL;
         end else begin
            bus.Dig_out <= 2'b10 ^ DIG_POL;
            bus.Seg_out <= seg_pattern(bus.Bcd_out[3:0]) ^ SEG_POL;
         end
      end
   end

endmodule

// File: tb/tb_sum_display_driver.sv
// Scoreboard bench for sum_display_driver: loads push expected BCD results,
// a monitor pops and compares them whenever a conversion completes.
module tb_sum_display_driver;

   logic Clk_in   = 1'b0;
   logic Rst_n_in = 1'b0;

   sum_display_driver_if bus ();

   sum_display_driver #(
      .CLK_HZ         (1000),
      .REFRESH_HZ     (100),
      .ACTIVE_LOW_SEG (1'b1)
   ) dut (
      .Clk_in   (Clk_in),
      .Rst_n_in (Rst_n_in),
      .bus      (bus)
   );

   always #5 Clk_in = ~Clk_in;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];
   logic       prev_busy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: a falling Busy_out outside reset presents a finished result.
   always @(negedge Clk_in) begin
      if (Rst_n_in && prev_busy && !bus.Busy_out) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_result: got bcd=%0h expected no result", bus.Bcd_out);
         end else begin
            check("bcd_result", {24'h0, bus.Bcd_out}, {24'h0, exp_q.pop_front()});
         end
      end
      prev_busy = bus.Busy_out;
   end

   task automatic tick();
      @(posedge Clk_in);
      #1;
   endtask

   // Drives a one-cycle load; returns just after load edge k.
   task automatic load(input logic [4:0] v, input bit expect_result, input logic [7:0] exp);
      bus.Sum_in   = v;
      bus.Valid_in = 1'b1;
      if (expect_result) exp_q.push_back(exp);
      tick();
      bus.Valid_in = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.Busy_out && n < 20) begin
         tick();
         n++;
      end
      check(name, {31'h0, bus.Busy_out}, 32'h0);
   endtask

   // Lets the new result reach the display, then finds the requested slot.
   task automatic check_slot(input string name, input logic [1:0] dig, input logic [6:0] seg);
      int n = 0;
      repeat (2) tick();
      while (bus.Dig_out !== dig && n < 20) begin
         tick();
         n++;
      end
      check({name, "_dig"}, {30'h0, bus.Dig_out}, {30'h0, dig});
      check({name, "_seg"}, {25'h0, bus.Seg_out}, {25'h0, seg});
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      bus.Sum_in   = 5'd0;
      bus.Valid_in = 1'b0;

      // Reset held with clock running
      repeat (3) tick();
      check("rst_busy", {31'h0, bus.Busy_out}, 32'h0);
      check("rst_bcd",  {24'h0, bus.Bcd_out},  32'h00);
      check("rst_seg",  {25'h0, bus.Seg_out},  32'h7F);
      check("rst_dig",  {30'h0, bus.Dig_out},  32'h3);

      // Release: edges 1..5 ones, 6..10 tens, 11 ones again
      Rst_n_in = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick();
         check($sformatf("refresh_dig_%0d", i), {30'h0, bus.Dig_out},
               ((((i - 1) / 5) % 2) == 1) ? 32'h1 : 32'h2);
         if (i == 1) check("zero_ones_seg", {25'h0, bus.Seg_out}, 32'h40);
         if (i == 6) check("zero_tens_blank", {25'h0, bus.Seg_out}, 32'h7F);
      end

      // Sum 30: busy timing and display
      load(5'd30, 1'b1, 8'h30);
      check("busy_k", {31'h0, bus.Busy_out}, 32'h1);
      for (int j = 1; j <= 5; j++) begin
         tick();
         check($sformatf("busy_k%0d", j), {31'h0, bus.Busy_out}, 32'h1);
         check($sformatf("bcd_hold_k%0d", j), {24'h0, bus.Bcd_out}, 32'h00);
      end
      tick();
      check("busy_k6", {31'h0, bus.Busy_out}, 32'h0);
      check("bcd_k6",  {24'h0, bus.Bcd_out},  32'h30);
      check_slot("s30_ones", 2'b10, 7'h40);
      check_slot("s30_tens", 2'b01, 7'h30);

      // Sum 7: tens blanked
      load(5'd7, 1'b1, 8'h07);
      wait_idle("idle_7");
      check_slot("s7_ones", 2'b10, 7'h78);
      check_slot("s7_tens", 2'b01, 7'h7F);

      // Valid during SHIFT (k+2) and DONE (k+6) is ignored
      load(5'd30, 1'b1, 8'h30);
      tick();
      bus.Sum_in = 5'd9;
      bus.Valid_in = 1'b1;
      tick();
      bus.Valid_in = 1'b0;
      repeat (3) tick();
      bus.Valid_in = 1'b1;
      tick();
      bus.Valid_in = 1'b0;
      check("ign_busy_k6", {31'h0, bus.Busy_out}, 32'h0);
      check("ign_bcd_k6",  {24'h0, bus.Bcd_out},  32'h30);
      repeat (8) tick();
      check("ign_busy_late", {31'h0, bus.Busy_out}, 32'h0);
      check("ign_bcd_late",  {24'h0, bus.Bcd_out},  32'h30);

      // Reset mid-conversion aborts without committing
      load(5'd31, 1'b0, 8'h00);
      repeat (3) tick();
      Rst_n_in = 1'b0;
      #1;
      check("abort_busy", {31'h0, bus.Busy_out}, 32'h0);
      check("abort_bcd",  {24'h0, bus.Bcd_out},  32'h00);
      check("abort_seg",  {25'h0, bus.Seg_out},  32'h7F);
      check("abort_dig",  {30'h0, bus.Dig_out},  32'h3);
      tick();
      Rst_n_in = 1'b1;
      tick();
      load(5'd31, 1'b1, 8'h31);
      repeat (6) tick();
      check("reload_bcd", {24'h0, bus.Bcd_out}, 32'h31);

      // Sweep of all 32 input values
      for (int v = 0; v < 32; v++) begin
         load(5'(v), 1'b1, 8'(((v / 10) << 4) | (v % 10)));
         wait_idle($sformatf("sweep_idle_%0d", v));
         tick();
      end

      repeat (3) tick();
      check("queue_drained", exp_q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sum_display_driver.md
Name: sum_display_driver

Overview:
- Downstream consumer of the 4-bit operand adder's 5-bit sum (0..31).
- Captures the sum on a load strobe and converts it to two BCD digits with a sequential double-dabble (shift-add-3) engine.
- Drives a 2-digit multiplexed 7-segment display on the practicum board, with leading-zero blanking on the tens digit.
- Display refresh runs continuously and independently of conversion.

Parameters:
- CLK_HZ, 50000000, board clock frequency in Hz.
- REFRESH_HZ, 1000, per-digit refresh rate in Hz. DIV = CLK_HZ/(2*REFRESH_HZ) cycles per digit slot; DIV >= 2.
- ACTIVE_LOW_SEG, 1, 1: segment and digit outputs are active-low; 0: both are active-high.

Ports:
- Clk_in  input  1  system clock, rising edge.
- Rst_n_in  input  1  asynchronous active-low reset.
- Sum_in  input  5  unsigned sum from the adder stage.
- Valid_in  input  1  load strobe; sampled only in IDLE.
- Busy_out  output  1  high while a conversion is in progress.
- Bcd_out  output  8  [7:4] tens, [3:0] ones of the last completed conversion.
- Seg_out  output  7  segments gfedcba, bit0 = a.
- Dig_out  output  2  digit enables: [0] ones, [1] tens.

Behaviour:
- Reset is asynchronous, active-low, and one clock only.
- Reset values (ACTIVE_LOW_SEG=1):
  - Busy_out=0, Bcd_out=8'h00.
  - Seg_out=7'h7F, all segments off.
  - Dig_out=2'b11, no digit on.
  - FSM=IDLE, refresh counter=0, digit select=ones.
- With ACTIVE_LOW_SEG=0, every display value is inverted: Seg_out=7'h00, Dig_out=2'b00.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if Valid_in=1 at edge k, latch Sum_in into a 13-bit shift register (bcd[7:0] cleared, bin[4:0]=Sum_in). Clear the step count; go to SHIFT. Busy_out=1 after edge k.
  - SHIFT: each edge, add 3 to any BCD nibble >= 5, then shift the whole register left by one.
    - Five steps occur, on edges k+1..k+5.
    - At edge k+5 go to DONE.
  - DONE: at edge k+6, Bcd_out <= converted BCD, Busy_out <= 0, go to IDLE.
  - Total latency: Valid_in sampled at edge k, result visible after edge k+6.
  - Earliest next load is edge k+7.
- Valid_in in SHIFT or DONE is ignored and is not queued. Sum_in is don't-care outside the IDLE load edge.
- Bcd_out changes only at the DONE edge, never shows a partial result, and holds between conversions.
- All 32 input values convert correctly: 0..31 maps to 8'h00..8'h31.
- Refresh:
  - A free-running counter counts 0..DIV-1. At DIV-1 it wraps and toggles the digit select.
  - Seg_out and Dig_out are registered from the select and Bcd_out.
  - The first edge after reset release drives the ones digit (Dig_out=2'b10 active-low).
  - Refresh is unaffected by conversion activity.
- Ones slot: Dig_out=2'b10, Seg_out=pattern(ones).
- Tens slot: Dig_out=2'b01, Seg_out=pattern(tens), or 7'h7F if tens==0 (leading-zero blank).
- Active-low patterns (gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
- If Bcd_out changes mid-slot, the new value appears on the next clock edge in that slot.
- Reset mid-conversion aborts the conversion immediately. Bcd_out keeps its reset value; no partial result is committed.

Test Plan (CLK_HZ=1000, REFRESH_HZ=100, so DIV=5):
- Reset with Rst_n_in=0 held and clock running -> Busy_out=0, Bcd_out=00, Seg_out=7F, Dig_out=11. After release: Dig_out=10 on first edge, toggles every 5 edges.
- Sum_in=30 with a one-cycle Valid_in at edge k -> Busy_out=1 from k through k+5, 0 after k+6, Bcd_out=8'h30 after k+6. Ones slot shows Seg_out=40; tens slot shows Seg_out=30.
- Sum_in=7 load -> Bcd_out=8'h07. Ones slot shows Seg_out=78; tens slot (Dig_out=01) shows Seg_out=7F (blanked).
- Sum_in=30 load at k, then Sum_in=9 with Valid_in at k+2 and k+6 -> Bcd_out=8'h30 only; no second conversion; Busy_out low after k+6.
- Load Sum_in=31 at k and assert Rst_n_in=0 at k+3 -> outputs return to reset values immediately; Bcd_out=00. A subsequent load of 31 gives 8'h31 after 6 edges.
- Sweep Sum_in 0..31, each load waiting for Busy_out=0 -> Bcd_out matches the decimal value for all 32 values.
